// File: rtl/hp_fpu_sched.sv
`default_nettype none
// ============================================================================
// Module   : hp_fpu_sched
// Purpose  : Shares one half-precision FPU datapath between two requester
//            ports. A round-robin arbiter picks one request. The winning
//            operands and op code are registered towards the FPU. After
//            LATENCY execute cycles the FPU result and class flags are
//            captured and returned to the originating port on a valid/ready
//            response channel. The block also owns the 16-bit Galois LFSR
//            that feeds the stochastic-rounding ops.
// Ports    : clk, rst_n (async, active low)
//            req{0,1}_valid/ready/a/b/op   : request channels
//            rsp{0,1}_valid/ready/res/flags: response channels
//            fpu_src_a/b, fpu_operation    : registered operands to the FPU
//            fpu_ops_ready                 : high throughout execute
//            fpu_res, fpu_flags            : combinational FPU result
//            sr_rand                       : LFSR state for SR rounding
// Revision : 1.0 - initial release
// ============================================================================
module hp_fpu_sched #(
    parameter int          LATENCY   = 1,        // 1..15
    parameter logic [15:0] LFSR_SEED = 16'hACE1  // must be non-zero
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_res,
    output logic [5:0]  rsp0_flags,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_res,
    output logic [5:0]  rsp1_flags,
    output logic [15:0] fpu_src_a,
    output logic [15:0] fpu_src_b,
    output logic [2:0]  fpu_operation,
    output logic        fpu_ops_ready,
    input  logic [15:0] fpu_res,
    input  logic [5:0]  fpu_flags,
    output logic [15:0] sr_rand
);

    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_EXEC      = 2'd1;
    localparam logic [1:0]  S_RESP      = 2'd2;
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;
    localparam logic [3:0]  C_LAT       = 4'(LATENCY);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_prio;     // port that wins when both request
    logic        r_owner;    // port that owns the outstanding operation
    logic [3:0]  r_cnt;
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_step;
    logic [15:0] r_src_a;
    logic [15:0] r_src_b;
    logic [2:0]  r_op;
    logic [15:0] r_res;
    logic [5:0]  r_flags;
    logic        w_grant;
    logic        w_accept;
    logic        w_cnt_last;
    logic        w_rsp_done;
    logic [15:0] w_sel_a;
    logic [15:0] w_sel_b;
    logic [2:0]  w_sel_op;

    // A lone requester always wins; the pointer only breaks ties.
    always_comb begin
        w_grant = r_prio;
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (w_grant ? req1_valid : req0_valid);
    assign w_cnt_last = (r_cnt == 4'd1);
    assign w_rsp_done = (r_state == S_RESP) && (r_owner ? rsp1_ready : rsp0_ready);

    assign w_sel_a  = w_grant ? req1_a  : req0_a;
    assign w_sel_b  = w_grant ? req1_b  : req0_b;
    assign w_sel_op = w_grant ? req1_op : req0_op;

    // Galois right-shift step; a non-zero state never maps to zero.
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ C_LFSR_TAPS) : (r_lfsr >> 1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_EXEC;
            S_EXEC:  if (w_cnt_last) w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_done) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_cnt   <= 4'd0;
            r_lfsr  <= LFSR_SEED;
            r_src_a <= 16'd0;
            r_src_b <= 16'd0;
            r_op    <= 3'd0;
            r_res   <= 16'd0;
            r_flags <= 6'd0;
        end else begin
            if (w_accept) begin
                r_src_a <= w_sel_a;
                r_src_b <= w_sel_b;
                r_op    <= w_sel_op;
                r_owner <= w_grant;
                r_prio  <= ~w_grant;
                r_cnt   <= C_LAT;
                // Step only for stochastic-rounding ops so sr_rand is
                // constant for the whole execute window.
                if (w_sel_op[0]) begin
                    r_lfsr <= w_lfsr_step;
                end
            end
            if (r_state == S_EXEC) begin
                r_cnt <= r_cnt - 4'd1;
                if (w_cnt_last) begin
                    r_res   <= fpu_res;
                    r_flags <= fpu_flags;
                end
            end
        end
    end

    assign req0_ready    = (r_state == S_IDLE) && req0_valid && !w_grant;
    assign req1_ready    = (r_state == S_IDLE) && req1_valid &&  w_grant;
    assign rsp0_valid    = (r_state == S_RESP) && !r_owner;
    assign rsp1_valid    = (r_state == S_RESP) &&  r_owner;
    // Only one rsp_valid is ever high, so both ports can share the capture register.
    assign rsp0_res      = r_res;
    assign rsp1_res      = r_res;
    assign rsp0_flags    = r_flags;
    assign rsp1_flags    = r_flags;
    assign fpu_src_a     = r_src_a;
    assign fpu_src_b     = r_src_b;
    assign fpu_operation = r_op;
    assign fpu_ops_ready = (r_state == S_EXEC);
    assign sr_rand       = r_lfsr;

endmodule
`default_nettype wire

// File: tb/tb_hp_fpu_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_hp_fpu_sched
// Purpose  : Self-checking bench for hp_fpu_sched. Four instances with
//            LATENCY 1, 3, 4 and 15 each get their own reset and stimulus.
//            The FPU is a stub whose output changes every cycle, so the
//            captured value identifies the cycle it was sampled in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hp_fpu_sched;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tick = 0;  // index of the current clock cycle
    always @(posedge clk) tick <= tick + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic        rst_n [N];
    logic        req0_valid [N], req1_valid [N], req0_ready [N], req1_ready [N];
    logic [15:0] req0_a [N], req0_b [N], req1_a [N], req1_b [N];
    logic [2:0]  req0_op [N], req1_op [N];
    logic        rsp0_valid [N], rsp1_valid [N], rsp0_ready [N], rsp1_ready [N];
    logic [15:0] rsp0_res [N], rsp1_res [N];
    logic [5:0]  rsp0_flags [N], rsp1_flags [N];
    logic [15:0] fpu_src_a [N], fpu_src_b [N], fpu_res [N], sr_rand [N];
    logic [2:0]  fpu_operation [N];
    logic        fpu_ops_ready [N];
    logic [5:0]  fpu_flags [N];
    bit          fixed [N];      // stub returns 1.0*2.0 = 2.0 when set

    logic        exp_prio [N];
    logic [15:0] exp_lfsr [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        hp_fpu_sched #(
            .LATENCY  (g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 15),
            .LFSR_SEED(16'hACE1)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n[g]),
            .req0_valid   (req0_valid[g]),
            .req0_ready   (req0_ready[g]),
            .req0_a       (req0_a[g]),
            .req0_b       (req0_b[g]),
            .req0_op      (req0_op[g]),
            .req1_valid   (req1_valid[g]),
            .req1_ready   (req1_ready[g]),
            .req1_a       (req1_a[g]),
            .req1_b       (req1_b[g]),
            .req1_op      (req1_op[g]),
            .rsp0_valid   (rsp0_valid[g]),
            .rsp0_ready   (rsp0_ready[g]),
            .rsp0_res     (rsp0_res[g]),
            .rsp0_flags   (rsp0_flags[g]),
            .rsp1_valid   (rsp1_valid[g]),
            .rsp1_ready   (rsp1_ready[g]),
            .rsp1_res     (rsp1_res[g]),
            .rsp1_flags   (rsp1_flags[g]),
            .fpu_src_a    (fpu_src_a[g]),
            .fpu_src_b    (fpu_src_b[g]),
            .fpu_operation(fpu_operation[g]),
            .fpu_ops_ready(fpu_ops_ready[g]),
            .fpu_res      (fpu_res[g]),
            .fpu_flags    (fpu_flags[g]),
            .sr_rand      (sr_rand[g])
        );
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 15;
        endcase
    endfunction

    function automatic logic [15:0] f_res(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op, input int t);
        logic [31:0] tt;
        tt = t;
        return a ^ {b[7:0], b[15:8]} ^ tt[15:0] ^ {13'd0, op};
    endfunction

    function automatic logic [5:0] f_flags(input logic [15:0] a, input logic [2:0] op,
                                           input int t);
        logic [31:0] tt;
        tt = t;
        return tt[5:0] ^ a[5:0] ^ {3'd0, op};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // FPU stub: result depends on the operands and on the current cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            fpu_res[i]   = fixed[i] ? 16'h4000 : f_res(fpu_src_a[i], fpu_src_b[i], fpu_operation[i], tick);
            fpu_flags[i] = fixed[i] ? 6'b000100 : f_flags(fpu_src_a[i], fpu_operation[i], tick);
        end
    end

    task automatic check(input int i, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL dut%0d %s: observed 0x%0h expected 0x%0h", i, tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete transaction: drive requests, expect the model's winner,
    // follow it through execute, optional backpressure and response.
    task automatic run_op(input int i, input bit v0, input bit v1,
                          input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] o0,
                          input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] o1,
                          input int hold, output bit win);
        int          t0, lat;
        logic [15:0] ea, eb, eres;
        logic [2:0]  eo;
        logic [5:0]  efl;
        lat = lat_of(i);
        req0_a[i] = a0; req0_b[i] = b0; req0_op[i] = o0;
        req1_a[i] = a1; req1_b[i] = b1; req1_op[i] = o1;
        req0_valid[i] = v0; req1_valid[i] = v1;
        win = (v0 && v1) ? exp_prio[i] : v1;
        #1;
        check(i, "req0_ready", req0_ready[i], v0 && !win);
        check(i, "req1_ready", req1_ready[i], v1 && win);
        t0 = tick;
        ea = win ? a1 : a0;
        eb = win ? b1 : b0;
        eo = win ? o1 : o0;
        if (eo[0]) exp_lfsr[i] = lfsr_next(exp_lfsr[i]);
        exp_prio[i] = !win;
        if (fixed[i]) begin
            eres = 16'h4000;
            efl  = 6'b000100;
        end else begin
            eres = f_res(ea, eb, eo, t0 + lat);
            efl  = f_flags(ea, eo, t0 + lat);
        end
        step();
        if (win) req1_valid[i] = 1'b0;
        else     req0_valid[i] = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            #1;
            check(i, "exec_ops_ready", fpu_ops_ready[i], 1);
            check(i, "exec_rsp0_valid", rsp0_valid[i], 0);
            check(i, "exec_rsp1_valid", rsp1_valid[i], 0);
            check(i, "exec_req_ready", {req0_ready[i], req1_ready[i]}, 0);
            check(i, "exec_src_a", fpu_src_a[i], ea);
            check(i, "exec_src_b", fpu_src_b[i], eb);
            check(i, "exec_op", fpu_operation[i], eo);
            check(i, "exec_sr_rand", sr_rand[i], exp_lfsr[i]);
            step();
        end
        #1;
        check(i, "rsp_owner_valid", win ? rsp1_valid[i] : rsp0_valid[i], 1);
        check(i, "rsp_other_valid", win ? rsp0_valid[i] : rsp1_valid[i], 0);
        check(i, "rsp_ops_ready", fpu_ops_ready[i], 0);
        check(i, "rsp_res", win ? rsp1_res[i] : rsp0_res[i], eres);
        check(i, "rsp_flags", win ? rsp1_flags[i] : rsp0_flags[i], efl);
        check(i, "rsp_req_ready", {req0_ready[i], req1_ready[i]}, 0);
        for (int h = 0; h < hold; h++) begin
            step();
            #1;
            check(i, "bp_valid", win ? rsp1_valid[i] : rsp0_valid[i], 1);
            check(i, "bp_res", win ? rsp1_res[i] : rsp0_res[i], eres);
            check(i, "bp_flags", win ? rsp1_flags[i] : rsp0_flags[i], efl);
            check(i, "bp_req_ready", {req0_ready[i], req1_ready[i]}, 0);
        end
        if (win) rsp1_ready[i] = 1'b1;
        else     rsp0_ready[i] = 1'b1;
        step();
        rsp0_ready[i] = 1'b0;
        rsp1_ready[i] = 1'b0;
        #1;
        check(i, "done_rsp_valid", {rsp0_valid[i], rsp1_valid[i]}, 0);
        check(i, "done_src_kept", fpu_src_a[i], ea);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit          w;
        logic [15:0] ra0, rb0, ra1, rb1;
        logic [2:0]  ro0, ro1;
        int          pat, hold;

        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0;
            req0_valid[i] = 0; req1_valid[i] = 0; rsp0_ready[i] = 0; rsp1_ready[i] = 0;
            req0_a[i] = 0; req0_b[i] = 0; req0_op[i] = 0;
            req1_a[i] = 0; req1_b[i] = 0; req1_op[i] = 0;
            fixed[i] = 0; exp_prio[i] = 0; exp_lfsr[i] = 16'hACE1;
        end

        // Reset values
        @(negedge clk);
        #1;
        check(0, "rst_req_ready", {req0_ready[0], req1_ready[0]}, 0);
        check(0, "rst_rsp_valid", {rsp0_valid[0], rsp1_valid[0]}, 0);
        check(0, "rst_ops_ready", fpu_ops_ready[0], 0);
        check(0, "rst_src_a", fpu_src_a[0], 0);
        check(0, "rst_src_b", fpu_src_b[0], 0);
        check(0, "rst_op", fpu_operation[0], 0);
        check(0, "rst_rsp_res", {rsp0_res[0], rsp1_res[0]}, 0);
        check(0, "rst_rsp_flags", {rsp0_flags[0], rsp1_flags[0]}, 0);
        check(0, "rst_sr_rand", sr_rand[0], 16'hACE1);
        @(negedge clk);
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        step();

        // Single MUL_RN 1.0 * 2.0, LATENCY 1
        fixed[0] = 1'b1;
        run_op(0, 1, 0, 16'h3C00, 16'h4000, 3'b100, 16'h0, 16'h0, 3'b000, 0, w);
        fixed[0] = 1'b0;

        // Contention from reset on the LATENCY 3 instance
        run_op(1, 1, 1, 16'h1111, 16'h2222, 3'b000, 16'h3333, 16'h4444, 3'b010, 0, w);
        run_op(1, 0, 1, 16'h1111, 16'h2222, 3'b000, 16'h3333, 16'h4444, 3'b010, 0, w);
        run_op(1, 1, 1, 16'h5555, 16'h6666, 3'b110, 16'h7777, 16'h8888, 3'b100, 0, w);
        run_op(1, 0, 1, 16'h5555, 16'h6666, 3'b110, 16'h7777, 16'h8888, 3'b100, 0, w);

        // Backpressure: 5 cycles of rsp_ready low with a pending second request
        run_op(0, 1, 1, 16'hA5A5, 16'h0F0F, 3'b111, 16'h5A5A, 16'hF0F0, 3'b011, 5, w);
        run_op(0, !w, w, 16'hA5A5, 16'h0F0F, 3'b111, 16'h5A5A, 16'hF0F0, 3'b011, 5, w);

        // LFSR sequence on the LATENCY 15 instance
        run_op(3, 1, 0, 16'h3C00, 16'h3C00, 3'b101, 16'h0, 16'h0, 3'b000, 0, w);
        check(3, "lfsr_first", sr_rand[3], 16'hE270);
        run_op(3, 1, 0, 16'h3C00, 16'h3C00, 3'b100, 16'h0, 16'h0, 3'b000, 0, w);
        check(3, "lfsr_after_rn", sr_rand[3], 16'hE270);
        run_op(3, 1, 0, 16'h3C00, 16'h3C00, 3'b101, 16'h0, 16'h0, 3'b000, 0, w);
        check(3, "lfsr_second", sr_rand[3], 16'h7138);

        // Reset in the second execute cycle, LATENCY 4
        req0_a[2] = 16'h1234; req0_b[2] = 16'h4321; req0_op[2] = 3'b101; req0_valid[2] = 1'b1;
        #1;
        check(2, "abort_accept", req0_ready[2], 1);
        step();
        req0_valid[2] = 1'b0;
        #1;
        check(2, "abort_exec1", fpu_ops_ready[2], 1);
        step();
        rst_n[2] = 1'b0;
        #1;
        check(2, "abort_ops_ready", fpu_ops_ready[2], 0);
        check(2, "abort_rsp_valid", {rsp0_valid[2], rsp1_valid[2]}, 0);
        check(2, "abort_src", {fpu_src_a[2], fpu_src_b[2]}, 0);
        check(2, "abort_op", fpu_operation[2], 0);
        check(2, "abort_sr_rand", sr_rand[2], 16'hACE1);
        step();
        rst_n[2] = 1'b1;
        exp_prio[2] = 1'b0;
        exp_lfsr[2] = 16'hACE1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check(2, "abort_no_rsp", {rsp0_valid[2], rsp1_valid[2], fpu_ops_ready[2]}, 0);
            step();
        end
        run_op(2, 1, 0, 16'hBEEF, 16'hCAFE, 3'b011, 16'h0, 16'h0, 3'b000, 1, w);

        // Randomised traffic on the LATENCY 3 instance
        for (int k = 0; k < 20; k++) begin
            pat  = $urandom_range(1, 3);
            hold = $urandom_range(0, 3);
            ra0 = 16'($urandom); rb0 = 16'($urandom); ro0 = 3'($urandom);
            ra1 = 16'($urandom); rb1 = 16'($urandom); ro1 = 3'($urandom);
            run_op(1, pat[0], pat[1], ra0, rb0, ro0, ra1, rb1, ro1, hold, w);
            if (pat == 3) begin
                run_op(1, w, !w, ra0, rb0, ro0, ra1, rb1, ro1, hold, w);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hp_fpu_sched.md
# hp_fpu_sched

Scheduler that shares the half-precision FPU datapath (classify → mul/addsub → rounding) between two requester ports. It arbitrates round-robin, registers the winning operands and op code into the FPU, and waits a fixed number of cycles for the combinational result. It then returns the result and class flags to the originating port over a valid/ready response channel. It also owns the 16-bit LFSR that supplies the random bits for the stochastic-rounding (`*_SR`) operations.

## Interface

**Parameters**
- `LATENCY`, default 1: number of EXEC cycles from operand drive to result capture; legal range 1..15.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

**Ports**
- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid`, `req1_valid` in 1: request present on port 0 / port 1.
- `req0_ready`, `req1_ready` out 1: request accepted on the cycle where `valid & ready`.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 16: operands.
- `req0_op`, `req1_op` in 3: FPU op code (ADD_RN=000 … DIV_SR=111); bit 0 set selects stochastic rounding.
- `rsp0_valid`, `rsp1_valid` out 1: response present.
- `rsp0_ready`, `rsp1_ready` in 1: requester takes the response.
- `rsp0_res`, `rsp1_res` out 16: result.
- `rsp0_flags`, `rsp1_flags` out 6: {zero, inf, subN, Norm, QNan, SNan}.
- `fpu_src_a`, `fpu_src_b` out 16: registered operands to the FPU.
- `fpu_operation` out 3: registered op code.
- `fpu_ops_ready` out 1: high throughout EXEC.
- `fpu_res` in 16: FPU result.
- `fpu_flags` in 6: FPU flags, same order as `rsp*_flags`.
- `sr_rand` out 16: current LFSR state, fed to stochastic rounding.

## Operation

- FSM states: IDLE, EXEC, RESP. One operation is outstanding at a time.
- **IDLE**
  - Grant logic: if only one port is valid, that port wins. If both are valid, the port named by the priority pointer `prio` wins.
  - `reqN_ready = (state==IDLE) && grant==N`. The losing port sees ready low.
  - On handshake:
    - Register a/b/op into the `fpu_*` outputs.
    - Latch the owner port.
    - Set `prio` to the other port.
    - Load the cycle counter with `LATENCY`.
    - If `op[0]==1`, advance the LFSR one step.
    - Go to EXEC.
- **LFSR:** Galois, right shift. `next = state[0] ? (state>>1) ^ 16'hB400 : state>>1`. It never reaches zero. It is held constant in all other cycles, so `sr_rand` is stable through EXEC.
- **EXEC**
  - `fpu_ops_ready=1` and the counter decrements each cycle.
  - On the cycle the counter equals 1, capture `fpu_res`/`fpu_flags` into the response register and go to RESP.
- **RESP**
  - The owner's `rspN_valid=1`. The other port's `rsp_valid` stays 0.
  - Data and flags are held stable until `rspN_ready`.
  - On handshake go to IDLE. `fpu_src_*` and `fpu_operation` keep their last values.
- Requests arriving during EXEC/RESP are not accepted. Requesters must hold valid and data until ready.
- All 8 op codes are forwarded unchanged. Flags and result for ADD/SUB/DIV are passed through exactly as the FPU drives them; the scheduler does not validate them.

## Timing

- **Reset (async assert, sync-free deassert)**
  - State goes to IDLE and `prio` to 0.
  - `sr_rand` = `LFSR_SEED`.
  - All `req*_ready`, `rsp*_valid` and `fpu_ops_ready` are 0.
  - `fpu_src_a`, `fpu_src_b`, `fpu_operation`, `rsp*_res` and `rsp*_flags` are 0.
- **Reset mid-EXEC or mid-RESP:** the operation is aborted and no response is ever issued for it.
- **Latency**
  - Handshake at cycle T puts EXEC at T+1..T+LATENCY, and `rsp_valid` rises at T+LATENCY+1.
  - If `rsp_ready` is high on that cycle, IDLE is at T+LATENCY+2, and the next accept is possible at T+LATENCY+2.
  - Peak throughput is 1 op per LATENCY+2 cycles.
- **Simultaneous events:** a request valid in the same cycle as the RESP handshake is not accepted until the following IDLE cycle.
- **Backpressure:** `rsp_valid` stays high indefinitely with constant data. Both `req_ready` stay low.

## Test plan

- **Single MUL:** port 0 MUL_RN, a=16'h3C00, b=16'h4000, LATENCY=1, accepted at cycle 0.
  - `fpu_ops_ready` is high at cycle 1.
  - `rsp0_valid` at cycle 2 with `rsp0_res`=16'h4000 and flags=6'b000100.
  - `rsp1_valid` stays 0.
- **Contention:** both ports valid from reset.
  - Port 0 is granted first, port 1 second.
  - Re-assert both: port 0 is granted third.
  - `req1_ready` is never high while port 0 is granted.
- **Backpressure:** hold `rsp0_ready`=0 for 5 cycles in RESP.
  - `rsp0_res` and flags are unchanged.
  - Both `req_ready` are 0.
  - The response completes on the cycle ready rises.
- **LFSR:** two MUL_SR ops after reset.
  - `sr_rand` is 16'hE270 during the first EXEC and 16'h7138 during the second.
  - An intervening MUL_RN leaves it unchanged.
- **Reset mid-EXEC:** assert `rst_n`=0 with LATENCY=4 at EXEC cycle 2.
  - All outputs go to reset values immediately.
  - No `rsp_valid` appears afterward, and the next request is accepted normally.
- **LATENCY sweep:** run 1, 3 and 15.
  - `rsp_valid` appears exactly LATENCY+1 cycles after accept.
  - The result equals the FPU value sampled in the last EXEC cycle.
